// File: rtl/ifu_pkg.sv
// ifu_pkg: shared types and constants for the instruction-fetch unit.
// fetch_entry_t pairs a fetched instruction word with its PC.
package ifu_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ifu_fetch_fifo: synchronous FIFO of {pc,inst} entries for the IDU.
// Ports: push/push_data, pop, flush (wins over push/pop), head, count.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          full;
  logic          do_pop;
  logic          do_push;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & (count != '0);
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

  // The issue credit must make this unreachable.
  a_no_overflow: assert property (
    @(posedge clock) disable iff (reset)
      !(push && !flush && full && !pop)
  );

endmodule

// File: rtl/ifu_fetch_unit.sv
// ifu_fetch_unit: fetch PC, in-order imem requests, wrong-path kill,
// fetch buffer to the IDU and the fence.i icache-invalidate handshake.
// Ports: clock/reset, dnpc/dnpc_flag/IFU_stall/icache_clr from control,
// imem_req_* / imem_rsp_*, icache_inv pulse, IDU_valid/IDU_inst/IDU_pc.
module ifu_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int          FIFO_DEPTH      = 2,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dnpc,
  input  logic        dnpc_flag,
  input  logic        IFU_stall,
  input  logic        icache_clr,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        icache_inv,
  output logic        IDU_valid,
  output logic [31:0] IDU_inst,
  output logic [31:0] IDU_pc
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic [31:0]   fetch_pc;
  logic [31:0]   rsp_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_nxt;
  logic [OW-1:0] kill_cnt;
  logic [OW-1:0] kill_nxt;
  logic          clr_pending;
  logic          clr_nxt;
  logic [FW-1:0] fifo_count;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;
  logic [31:0]   occupancy;
  logic          req_fire;
  logic          rsp_keep;
  logic          fifo_pop;
  logic          drain_done;

  assign IDU_valid = (fifo_count != '0);
  assign IDU_pc    = IDU_valid ? fifo_head.pc : '0;
  assign IDU_inst  = IDU_valid ? fifo_head.inst : '0;
  assign fifo_pop  = IDU_valid & ~IFU_stall;

  assign drain_done = clr_pending & (outstanding == '0);
  assign icache_inv = drain_done;

  // A slot freed by this cycle's pop counts as credit, so a
  // 1-cycle memory sustains one instruction per cycle.
  assign occupancy = 32'(outstanding) + 32'(fifo_count)
                   - 32'(fifo_pop);

  assign imem_req_valid = ~reset & ~dnpc_flag & ~clr_pending
    & (32'(outstanding) < 32'(MAX_OUTSTANDING))
    & (occupancy < 32'(FIFO_DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;

  assign rsp_keep   = imem_rsp_valid & (kill_cnt == '0) & ~dnpc_flag;
  assign push_entry = '{pc: rsp_pc, inst: imem_rsp_data};

  ifu_fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (rsp_keep),
    .push_data(push_entry),
    .pop      (fifo_pop),
    .flush    (dnpc_flag),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  always_comb begin
    outstanding_nxt = outstanding;
    unique case ({req_fire, imem_rsp_valid})
      2'b10:   outstanding_nxt = outstanding + OW'(1);
      2'b01:   outstanding_nxt = outstanding - OW'(1);
      default: ;
    endcase
  end

  // On a redirect every request still in flight is wrong-path,
  // including ones already marked by an earlier redirect, so the
  // new kill count is simply what remains in flight after this cycle.
  always_comb begin
    kill_nxt = kill_cnt;
    if (dnpc_flag) begin
      kill_nxt = imem_rsp_valid ? outstanding - OW'(1)
                                : outstanding;
    end else if (imem_rsp_valid && kill_cnt != '0) begin
      kill_nxt = kill_cnt - OW'(1);
    end
  end

  always_comb begin
    clr_nxt = clr_pending;
    if (drain_done)      clr_nxt = 1'b0;
    else if (icache_clr) clr_nxt = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      kill_cnt    <= '0;
      clr_pending <= 1'b0;
    end else begin
      if (dnpc_flag) begin
        fetch_pc <= dnpc;
        rsp_pc   <= dnpc;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (rsp_keep) rsp_pc   <= rsp_pc + STEP;
      end
      outstanding <= outstanding_nxt;
      kill_cnt    <= kill_nxt;
      clr_pending <= clr_nxt;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_unit.sv
// tb_ifu_fetch_unit: directed bench for ifu_fetch_unit with an
// in-order imem model of configurable latency.
module tb_ifu_fetch_unit;

  localparam logic [31:0] RST = 32'h8000_0000;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] dnpc = '0;
  logic        dnpc_flag = 1'b0;
  logic        IFU_stall = 1'b0;
  logic        icache_clr = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        icache_inv;
  logic        IDU_valid;
  logic [31:0] IDU_inst;
  logic [31:0] IDU_pc;

  int checks = 0;
  int failures = 0;
  int lat = 1;
  int cyc = 0;
  int inv_cnt = 0;

  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] acc_addr[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_inst[$];

  ifu_fetch_unit dut (
    .clock         (clock),
    .reset         (reset),
    .dnpc          (dnpc),
    .dnpc_flag     (dnpc_flag),
    .IFU_stall     (IFU_stall),
    .icache_clr    (icache_clr),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .icache_inv    (icache_inv),
    .IDU_valid     (IDU_valid),
    .IDU_inst      (IDU_inst),
    .IDU_pc        (IDU_pc)
  );

  initial forever #5 clock = ~clock;

  // Mid-cycle view: record accepted requests and consumed entries.
  always @(negedge clock) begin
    if (reset) begin
      acc_addr.delete();
      log_pc.delete();
      log_inst.delete();
      inv_cnt = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat);
        acc_addr.push_back(imem_req_addr);
      end
      if (IDU_valid && !IFU_stall && !dnpc_flag) begin
        log_pc.push_back(IDU_pc);
        log_inst.push_back(IDU_inst);
      end
      if (icache_inv) inv_cnt++;
    end
  end

  // Memory responses, in order, lat cycles after acceptance.
  always @(posedge clock) begin
    cyc++;
    #2;
    if (reset) begin
      mq_addr.delete();
      mq_due.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end else if (mq_addr.size() != 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mq_addr[0] ^ KEY;
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  end

  task automatic cycle_step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int l);
    reset = 1'b1;
    dnpc_flag = 1'b0;
    icache_clr = 1'b0;
    IFU_stall = 1'b0;
    imem_req_ready = 1'b1;
    dnpc = '0;
    lat = l;
    repeat (2) @(posedge clock);
    @(negedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(1);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({imem_req_valid, icache_inv, IDU_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctl: got %b expected 000",
        {imem_req_valid, icache_inv, IDU_valid});
    end
    checks++;
    if ({IDU_pc, IDU_inst} !== 64'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0",
        {IDU_pc, IDU_inst});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RST}) begin
      failures++;
      $display("FAIL reset_first_req: got %b/%h expected 1/%h",
        imem_req_valid, imem_req_addr, RST);
    end
    cycle_step();
  endtask

  task automatic test_stream();
    int gaps = 0;
    int bad = 0;
    do_reset(1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      if (i >= 2 && IDU_valid !== 1'b1) gaps++;
      cycle_step();
    end
    checks++;
    if (gaps !== 0) begin
      failures++;
      $display("FAIL stream_gaps: got %0d expected 0", gaps);
    end
    checks++;
    if (log_pc.size() !== 10) begin
      failures++;
      $display("FAIL stream_count: got %0d expected 10",
        log_pc.size());
    end
    for (int i = 0; i < log_pc.size(); i++) begin
      if (log_pc[i] !== RST + 32'(4 * i)) bad++;
      if (log_inst[i] !== ((RST + 32'(4 * i)) ^ KEY)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL stream_order: got %0d bad expected 0", bad);
    end
    checks++;
    if (acc_addr.size() < 3 || acc_addr[2] !== RST + 32'h8) begin
      failures++;
      $display("FAIL stream_addr2: got %0d reqs expected %h at 2",
        acc_addr.size(), RST + 32'h8);
    end
  endtask

  task automatic test_ready_hold();
    int bad = 0;
    do_reset(1);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if ({imem_req_valid, imem_req_addr} !== {1'b1, RST}) bad++;
      cycle_step();
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL ready_hold: got %0d bad expected 0", bad);
    end
    imem_req_ready = 1'b1;
    repeat (4) cycle_step();
    checks++;
    if (acc_addr.size() < 2 || acc_addr[0] !== RST ||
        acc_addr[1] !== RST + 32'h4) begin
      failures++;
      $display("FAIL ready_resume: got %0d reqs expected %h,%h",
        acc_addr.size(), RST, RST + 32'h4);
    end
  endtask

  task automatic test_redirect();
    int bad = 0;
    logic [31:0] tgt = 32'h8000_0100;
    do_reset(3);
    cycle_step();
    cycle_step();
    dnpc_flag = 1'b1;
    dnpc = tgt;
    @(negedge clock);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL redirect_noreq: got %b expected 0",
        imem_req_valid);
    end
    cycle_step();
    dnpc_flag = 1'b0;
    repeat (14) cycle_step();
    checks++;
    if (acc_addr.size() < 3 || acc_addr[2] !== tgt) begin
      failures++;
      $display("FAIL redirect_req: got %0d reqs expected %h at 2",
        acc_addr.size(), tgt);
    end
    checks++;
    if (log_pc.size() < 3 || log_pc[0] !== tgt) begin
      failures++;
      $display("FAIL redirect_first: got %0d entries expected %h",
        log_pc.size(), tgt);
    end
    for (int i = 0; i < log_pc.size(); i++) begin
      if (log_pc[i] !== tgt + 32'(4 * i)) bad++;
      if (log_inst[i] !== (log_pc[i] ^ KEY)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL redirect_path: got %0d bad expected 0", bad);
    end
  endtask

  task automatic test_stall();
    int bad = 0;
    int max_occ = 0;
    int occ;
    do_reset(1);
    repeat (3) cycle_step();
    IFU_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if ({IDU_valid, IDU_pc, IDU_inst} !==
          {1'b1, RST + 32'h4, (RST + 32'h4) ^ KEY}) begin
        failures++;
        $display("FAIL stall_hold%0d: got %b/%h/%h expected 1/%h",
          i, IDU_valid, IDU_pc, IDU_inst, RST + 32'h4);
      end
      cycle_step();
      occ = acc_addr.size() - log_pc.size();
      if (occ > max_occ) max_occ = occ;
    end
    checks++;
    if (max_occ > 2) begin
      failures++;
      $display("FAIL stall_credit: got %0d expected <=2", max_occ);
    end
    IFU_stall = 1'b0;
    repeat (6) cycle_step();
    for (int i = 0; i < log_pc.size(); i++) begin
      if (log_pc[i] !== RST + 32'(4 * i)) bad++;
    end
    checks++;
    if (bad !== 0 || log_pc.size() < 6) begin
      failures++;
      $display("FAIL stall_order: got %0d bad of %0d expected 0",
        bad, log_pc.size());
    end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    logic [31:0] a = 32'h8000_0200;
    logic [31:0] b = 32'h8000_0300;
    do_reset(3);
    cycle_step();
    cycle_step();
    dnpc_flag = 1'b1;
    dnpc = a;
    cycle_step();
    dnpc = b;
    cycle_step();
    dnpc_flag = 1'b0;
    repeat (16) cycle_step();
    checks++;
    if (acc_addr.size() < 3 || acc_addr[2] !== b) begin
      failures++;
      $display("FAIL b2b_req: got %0d reqs expected %h at 2",
        acc_addr.size(), b);
    end
    checks++;
    if (log_pc.size() < 3 || log_pc[0] !== b) begin
      failures++;
      $display("FAIL b2b_first: got %0d entries expected %h",
        log_pc.size(), b);
    end
    for (int i = 0; i < log_pc.size(); i++) begin
      if (log_pc[i] !== b + 32'(4 * i)) bad++;
      if (log_inst[i] !== (log_pc[i] ^ KEY)) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL b2b_path: got %0d bad expected 0", bad);
    end
  endtask

  task automatic test_icache_clr();
    logic [31:0] tgt = 32'h8000_0400;
    do_reset(3);
    cycle_step();
    cycle_step();
    dnpc_flag = 1'b1;
    icache_clr = 1'b1;
    dnpc = tgt;
    cycle_step();
    dnpc_flag = 1'b0;
    icache_clr = 1'b0;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clock);
      checks++;
      if ({icache_inv, imem_req_valid} !==
          {1'(k == 5), 1'(k == 6)}) begin
        failures++;
        $display("FAIL clr_c%0d: got inv=%b req=%b expected %b/%b",
          k, icache_inv, imem_req_valid, k == 5, k == 6);
      end
      cycle_step();
    end
    repeat (10) cycle_step();
    checks++;
    if (inv_cnt !== 1) begin
      failures++;
      $display("FAIL clr_pulses: got %0d expected 1", inv_cnt);
    end
    checks++;
    if (acc_addr.size() < 3 || acc_addr[2] !== tgt) begin
      failures++;
      $display("FAIL clr_req: got %0d reqs expected %h at 2",
        acc_addr.size(), tgt);
    end
    checks++;
    if (log_pc.size() < 1 || log_pc[0] !== tgt) begin
      failures++;
      $display("FAIL clr_first: got %0d entries expected %h",
        log_pc.size(), tgt);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1);
    repeat (3) cycle_step();
    IFU_stall = 1'b1;
    repeat (3) cycle_step();
    @(negedge clock);
    checks++;
    if (IDU_valid !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre: got %b expected 1", IDU_valid);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({imem_req_valid, icache_inv, IDU_valid, IDU_pc, IDU_inst}
        !== 67'h0) begin
      failures++;
      $display("FAIL areset_now: got %b%b%b/%h/%h expected 0",
        imem_req_valid, icache_inv, IDU_valid, IDU_pc, IDU_inst);
    end
    IFU_stall = 1'b0;
    repeat (2) @(posedge clock);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({imem_req_valid, imem_req_addr} !== {1'b1, RST}) begin
      failures++;
      $display("FAIL areset_req: got %b/%h expected 1/%h",
        imem_req_valid, imem_req_addr, RST);
    end
    repeat (6) cycle_step();
    checks++;
    if (log_pc.size() < 1 || log_pc[0] !== RST) begin
      failures++;
      $display("FAIL areset_first: got %0d entries expected %h",
        log_pc.size(), RST);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_ready_hold();
    test_redirect();
    test_stall();
    test_back_to_back();
    test_icache_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
